axi_lite_reg_slave: RTL

AXI4-Lite subordinate (responder) exposing NUM_REGS 32-bit read/write control registers to the PS/VIP master. It is the register front end of the vector-processor control IP. Register contents are driven flat to the fabric, together with per-register one-cycle write strobes. It supports one outstanding write and one outstanding read, with independent AW and W acceptance.

---
 rtl/axi_lite_pkg.sv | 33 +++
 rtl/axi_lite_wr_ctrl.sv | 136 +++++++++++++
 rtl/axi_lite_reg_slave.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and helpers for the vector-processor control register front end.
// Holds the response encoding, word-addressing constants and the byte-lane merge function.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam int ADDR_LSB   = 2;
    localparam int WORD_BYTES = 4;

    // Merge new_word into old_word on the byte lanes enabled by strb.
    function automatic logic [31:0] apply_wstrb(
        input logic [31:0]           old_word,
        input logic [31:0]           new_word,
        input logic [WORD_BYTES-1:0] strb
    );
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_wr_ctrl.sv
// AXI4-Lite write-side control: captures AW and W independently, issues a one-cycle
// commit once both are held, then owns the B response until the master accepts it.
module axi_lite_wr_ctrl
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [IDX_W-1:0]        i_awidx,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic                    o_commit,
    output logic                    o_addr_ok,
    output logic [IDX_W-1:0]        o_idx,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic [DATA_WIDTH/8-1:0] o_strb
);

    typedef enum logic [2:0] {
        WR_IDLE    = 3'd0,
        WR_AW_HELD = 3'd1,
        WR_W_HELD  = 3'd2,
        WR_COMMIT  = 3'd3,
        WR_BRESP   = 3'd4
    } wr_state_t;

    localparam logic [IDX_W:0] NUM_REGS_EXT = (IDX_W+1)'(NUM_REGS);

    wr_state_t               r_state;
    wr_state_t               w_state_next;
    logic                    r_awready;
    logic                    r_wready;
    logic                    r_bvalid;
    resp_t                   r_bresp;
    logic [IDX_W-1:0]        r_idx;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH/8-1:0] r_strb;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_addr_ok;

    assign w_aw_hs   = i_awvalid && r_awready;
    assign w_w_hs    = i_wvalid && r_wready;
    assign w_addr_ok = ({1'b0, r_idx} < NUM_REGS_EXT);

    // Next-state decode; the COMMIT state lasts exactly one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WR_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_state_next = WR_COMMIT;
                end else if (w_aw_hs) begin
                    w_state_next = WR_AW_HELD;
                end else if (w_w_hs) begin
                    w_state_next = WR_W_HELD;
                end else begin
                    w_state_next = WR_IDLE;
                end
            end
            WR_AW_HELD: begin
                if (w_w_hs) begin
                    w_state_next = WR_COMMIT;
                end else begin
                    w_state_next = WR_AW_HELD;
                end
            end
            WR_W_HELD: begin
                if (w_aw_hs) begin
                    w_state_next = WR_COMMIT;
                end else begin
                    w_state_next = WR_W_HELD;
                end
            end
            WR_COMMIT: w_state_next = WR_BRESP;
            WR_BRESP: begin
                if (i_bready) begin
                    w_state_next = WR_IDLE;
                end else begin
                    w_state_next = WR_BRESP;
                end
            end
            default: w_state_next = WR_IDLE;
        endcase
    end

    // State, registered handshake outputs and captured AW/W payload.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= WR_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
            r_idx     <= {IDX_W{1'b0}};
            r_data    <= {DATA_WIDTH{1'b0}};
            r_strb    <= {(DATA_WIDTH/8){1'b0}};
        end else begin
            r_state   <= w_state_next;
            r_awready <= (w_state_next == WR_IDLE) || (w_state_next == WR_W_HELD);
            r_wready  <= (w_state_next == WR_IDLE) || (w_state_next == WR_AW_HELD);
            r_bvalid  <= (w_state_next == WR_BRESP);
            if (w_aw_hs) begin
                r_idx <= i_awidx;
            end
            if (w_w_hs) begin
                r_data <= i_wdata;
                r_strb <= i_wstrb;
            end
            if (r_state == WR_COMMIT) begin
                r_bresp <= w_addr_ok ? OKAY : SLVERR;
            end
        end
    end

    assign o_awready = r_awready;
    assign o_wready  = r_wready;
    assign o_bvalid  = r_bvalid;
    assign o_bresp   = r_bresp;
    assign o_commit  = (r_state == WR_COMMIT);
    assign o_addr_ok = w_addr_ok;
    assign o_idx     = r_idx;
    assign o_data    = r_data;
    assign o_strb    = r_strb;

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register front end: NUM_REGS word registers driven flat to the fabric with
// per-register write pulses; one outstanding read and one outstanding write.
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_REGS   = 4
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          S_AWADDR,
    input  logic [2:0]                     S_AWPROT,
    input  logic                           S_AWVALID,
    output logic                           S_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_WSTRB,
    input  logic                           S_WVALID,
    output logic                           S_WREADY,
    output logic [1:0]                     S_BRESP,
    output logic                           S_BVALID,
    input  logic                           S_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_ARADDR,
    input  logic [2:0]                     S_ARPROT,
    input  logic                           S_ARVALID,
    output logic                           S_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_RDATA,
    output logic [1:0]                     S_RRESP,
    output logic                           S_RVALID,
    input  logic                           S_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int IDX_W = ADDR_WIDTH - ADDR_LSB;
    localparam logic [IDX_W:0] NUM_REGS_EXT = (IDX_W+1)'(NUM_REGS);

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_VALID = 1'b1
    } rd_state_t;

    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]     r_wr_pulse;
    logic [NUM_REGS-1:0]     w_wr_sel;
    logic                    w_commit;
    logic                    w_wr_ok;
    logic [IDX_W-1:0]        w_wr_idx;
    logic [DATA_WIDTH-1:0]   w_wr_data;
    logic [DATA_WIDTH/8-1:0] w_wr_strb;
    rd_state_t               r_rd_state;
    rd_state_t               w_rd_next;
    logic                    r_arready;
    logic                    r_rvalid;
    logic [DATA_WIDTH-1:0]   r_rdata;
    resp_t                   r_rresp;
    logic [IDX_W-1:0]        w_ar_idx;
    logic                    w_ar_ok;
    logic                    w_ar_hs;
    logic [DATA_WIDTH-1:0]   w_rd_word;
    logic                    w_unused;

    assign w_unused = ^{S_AWPROT, S_ARPROT, S_AWADDR[ADDR_LSB-1:0], S_ARADDR[ADDR_LSB-1:0]};

    axi_lite_wr_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W),
        .NUM_REGS   (NUM_REGS)
    ) u_wr_ctrl (
        .i_clk     (ACLK),
        .i_rst     (ARESET),
        .i_awidx   (S_AWADDR[ADDR_WIDTH-1:ADDR_LSB]),
        .i_awvalid (S_AWVALID),
        .o_awready (S_AWREADY),
        .i_wdata   (S_WDATA),
        .i_wstrb   (S_WSTRB),
        .i_wvalid  (S_WVALID),
        .o_wready  (S_WREADY),
        .o_bresp   (S_BRESP),
        .o_bvalid  (S_BVALID),
        .i_bready  (S_BREADY),
        .o_commit  (w_commit),
        .o_addr_ok (w_wr_ok),
        .o_idx     (w_wr_idx),
        .o_data    (w_wr_data),
        .o_strb    (w_wr_strb)
    );

    // One-hot register select for the committing write; out-of-range decodes select nothing.
    always_comb begin
        w_wr_sel = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wr_sel[i] = w_commit && w_wr_ok && (w_wr_idx == IDX_W'(i));
        end
    end

    // Register array and its write pulses.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wr_pulse <= {NUM_REGS{1'b0}};
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            r_wr_pulse <= w_wr_sel;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_sel[i]) begin
                    r_regs[i] <= apply_wstrb(r_regs[i], w_wr_data, w_wr_strb);
                end
            end
        end
    end

    assign w_ar_idx = S_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign w_ar_ok  = ({1'b0, w_ar_idx} < NUM_REGS_EXT);
    assign w_ar_hs  = S_ARVALID && r_arready;

    // Read mux as an OR of masked words so an undecoded index yields zero.
    always_comb begin
        w_rd_word = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            w_rd_word = w_rd_word | (r_regs[i] & {DATA_WIDTH{w_ar_idx == IDX_W'(i)}});
        end
    end

    // Read channel next-state decode.
    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE: begin
                if (w_ar_hs) begin
                    w_rd_next = RD_VALID;
                end else begin
                    w_rd_next = RD_IDLE;
                end
            end
            RD_VALID: begin
                if (S_RREADY) begin
                    w_rd_next = RD_IDLE;
                end else begin
                    w_rd_next = RD_VALID;
                end
            end
            default: w_rd_next = RD_IDLE;
        endcase
    end

    // Read state and registered R channel; data is sampled at the AR handshake edge.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rd_state <= RD_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= {DATA_WIDTH{1'b0}};
            r_rresp    <= OKAY;
        end else begin
            r_rd_state <= w_rd_next;
            r_arready  <= (w_rd_next == RD_IDLE);
            r_rvalid   <= (w_rd_next == RD_VALID);
            if (w_ar_hs) begin
                r_rdata <= w_rd_word;
                r_rresp <= w_ar_ok ? OKAY : SLVERR;
            end
        end
    end

    assign S_ARREADY    = r_arready;
    assign S_RVALID     = r_rvalid;
    assign S_RDATA      = r_rdata;
    assign S_RRESP      = r_rresp;
    assign reg_wr_pulse = r_wr_pulse;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[DATA_WIDTH*g +: DATA_WIDTH] = r_regs[g];
    end

endmodule
